// File: rtl/msk_pkg.sv
// Shared types and share-slicing helpers for the masked mux/skid slice.
// A sharing of `count` bits packs share s at [s*count +: count].
package msk_pkg;

    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StFull1 = 2'b10,
        StFull2 = 2'b11
    } skid_state_e;

    localparam string FV_TYPE_SHARING = "sharing";
    localparam string FV_TYPE_CONTROL = "control";
    localparam int unsigned FV_LATENCY = 1;

    // Flat index of (candidate, bit, share) inside a packed candidate vector.
    function automatic int unsigned bit_idx(input int unsigned cand, input int unsigned bit_i,
                                            input int unsigned share, input int unsigned count,
                                            input int unsigned d);
        return cand * count * d + share * count + bit_i;
    endfunction

endpackage

// File: rtl/msk_reg_en.sv
// Enabled register with async active-low clear, stored as one kept bus per share
// so no share lanes are ever merged by synthesis.
module msk_reg_en #(
    parameter int unsigned d     = 2,
    parameter int unsigned count = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [count*d-1:0] din,
    output logic [count*d-1:0] q
);

    for (genvar i = 0; i < d; i++) begin : g_share
        (* keep = "true", syn_keep = "true" *) logic [count-1:0] share_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                share_q <= '0;
            end else if (en) begin
                share_q <= din[i*count +: count];
            end
        end

        assign q[i*count +: count] = share_q;
    end

endmodule

// File: rtl/msk_muxn_skid.sv
// Masked N-input mux with control select, registered output and a 2-entry skid
// buffer on a valid/ready handshake. Every share lane is muxed and stored on its own.
module msk_muxn_skid
    import msk_pkg::*;
#(
    parameter int unsigned d     = 2,
    parameter int unsigned count = 1,
    parameter int unsigned n_in  = 4,
    parameter int unsigned sel_w = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [sel_w-1:0]        sel,
    input  logic [n_in*count*d-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [count*d-1:0]      out_data,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int unsigned SHARE_W = count;
    localparam int unsigned W       = count * d;

    skid_state_e state_q, state_d;
    logic        in_ready_q;
    logic        accept, emit;
    logic        out_en, skid_en, out_from_skid;
    logic [W-1:0] mux_data, out_din, skid_q, out_q;

    // Out-of-range selects match no candidate and fall through to an all-zero sharing.
    for (genvar i = 0; i < d; i++) begin : g_share_mux
        logic [SHARE_W-1:0] sh_mux;

        always_comb begin
            sh_mux = '0;
            for (int unsigned k = 0; k < n_in; k++) begin
                if (sel == sel_w'(k)) begin
                    sh_mux = in_data[bit_idx(k, 0, i, count, d) +: SHARE_W];
                end
            end
        end

        assign mux_data[i*SHARE_W +: SHARE_W] = sh_mux;
    end

    assign out_valid = (state_q != StEmpty);
    assign in_ready  = in_ready_q;
    assign accept    = in_valid & in_ready_q;
    assign emit      = out_valid & out_ready;

    always_comb begin
        state_d       = state_q;
        out_en        = 1'b0;
        skid_en       = 1'b0;
        out_from_skid = 1'b0;
        case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d = StFull1;
                    out_en  = 1'b1;
                end
            end
            StFull1: begin
                if (accept && emit) begin
                    out_en = 1'b1;
                end else if (accept) begin
                    state_d = StFull2;
                    skid_en = 1'b1;
                end else if (emit) begin
                    state_d = StEmpty;
                end
            end
            StFull2: begin
                if (emit) begin
                    state_d       = StFull1;
                    out_en        = 1'b1;
                    out_from_skid = 1'b1;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    // Per-bit select between same-index lanes; never crosses shares.
    assign out_din = out_from_skid ? skid_q : mux_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StEmpty;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != StFull2);
        end
    end

    msk_reg_en #(
        .d    (d),
        .count(count)
    ) u_skid_reg (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (skid_en),
        .din  (mux_data),
        .q    (skid_q)
    );

    msk_reg_en #(
        .d    (d),
        .count(count)
    ) u_out_reg (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (out_en),
        .din  (out_din),
        .q    (out_q)
    );

    assign out_data = out_q;

endmodule
